// File: rtl/clk_div_pkg.sv
// Shared constants and mode encoding for the
// programmable clock divider.
package clk_div_pkg;

  localparam int CNT_W_DEF = 26;

  // Half-period divisors from a 50 MHz clock
  localparam int DIV_1KHZ = 25000;
  localparam int DIV_1HZ  = 25_000_000;

  typedef enum logic {
    MODE_SQUARE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

endpackage

// File: rtl/clk_divider_prog.sv
// Programmable clock divider: square or pulse output,
// divisor loaded through a shadow register applied at wrap.
// Ports:
//   clk, rst      clock, async active-high reset
//   en            count enable (low = hold)
//   mode          0 square, 1 pulse (sampled at wrap)
//   div_val       requested divisor H
//   div_load      one-cycle strobe capturing div_val
//   clk_out       registered divided output
//   tick          one-cycle pulse after each wrap
//   load_pending  shadow divisor waiting for a wrap
//   div_active    divisor currently in use
module clk_divider_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int DEFAULT_DIV = DIV_1KHZ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             mode,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             load_pending,
  output logic [CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] DEF_DIV =
    CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE =
    CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic [CNT_W-1:0] eff_div;
  logic [CNT_W-1:0] term;
  logic             wrap;
  mode_e            mode_q;
  mode_e            mode_in;

  // Zero divisor behaves as one, so term never
  // underflows and a plain equality ends the period.
  always_comb begin
    eff_div = div_active;
    if (div_active == '0) begin
      eff_div = ONE;
    end
    term    = eff_div - ONE;
    wrap    = en && (cnt == term);
    mode_in = mode_e'(mode);
  end

  // Counter; an en-low load clears it so the
  // count always stays below the new divisor.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (en) begin
      if (wrap) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + ONE;
      end
    end else if (div_load) begin
      cnt <= '0;
    end
  end

  // Divisor, shadow and pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_active   <= DEF_DIV;
      shadow       <= DEF_DIV;
      load_pending <= 1'b0;
    end else if (!en) begin
      if (div_load) begin
        div_active   <= div_val;
        shadow       <= div_val;
        load_pending <= 1'b0;
      end
    end else if (wrap) begin
      // A load coinciding with the wrap wins
      // over an older shadow value.
      if (div_load) begin
        div_active <= div_val;
      end else if (load_pending) begin
        div_active <= shadow;
      end
      load_pending <= 1'b0;
    end else if (div_load) begin
      shadow       <= div_val;
      load_pending <= 1'b1;
    end
  end

  // Output stage. In pulse mode clk_out mirrors
  // tick; in square mode it toggles per wrap and
  // restarts high when entering from pulse mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_out <= 1'b0;
      tick    <= 1'b0;
      mode_q  <= MODE_SQUARE;
    end else if (wrap) begin
      tick   <= 1'b1;
      mode_q <= mode_in;
      if (mode_in == MODE_PULSE) begin
        clk_out <= 1'b1;
      end else if (mode_q == MODE_PULSE) begin
        clk_out <= 1'b1;
      end else begin
        clk_out <= ~clk_out;
      end
    end else begin
      tick <= 1'b0;
      if (mode_q == MODE_PULSE) begin
        clk_out <= 1'b0;
      end
    end
  end

endmodule

// File: doc/clk_divider_prog.md
CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter CNT_W, default 26, SHALL set the width of the counter and of all divisor ports.
REQ-002 Parameter DEFAULT_DIV, default 25000, SHALL set the half-period/pulse divisor applied after reset (1 kHz square output from 50 MHz).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous, active-high.
REQ-005 en  input  1  SHALL enable counting: high = count, low = hold.
REQ-006 mode  input  1  SHALL select the output mode: 0 = square (toggle per wrap), 1 = pulse (one cycle high per wrap).
REQ-007 div_val  input  CNT_W  SHALL carry the requested divisor H.
REQ-008 div_load  input  1  SHALL be a one-cycle strobe capturing div_val.
REQ-009 clk_out  output  1  SHALL be the registered divided output.
REQ-010 tick  output  1  SHALL be a registered one-cycle pulse per wrap, independent of mode.
REQ-011 load_pending  output  1  SHALL be high while a captured divisor awaits application.
REQ-012 div_active  output  CNT_W  SHALL show the divisor currently in use.

Function
REQ-013 Effective divisor SHALL be max(div_active, 1); div_val = 0 is treated as 1.
REQ-014 With en high, the counter SHALL count 0..H-1 and return to 0 on the edge where it equals H-1 (the "wrap").
REQ-015 tick SHALL be high exactly during the cycle after each wrap edge, i.e. once every H enabled cycles; H = 1 gives tick constantly high.
REQ-016 In square mode clk_out SHALL toggle at each wrap, giving period 2H cycles and 50% duty.
REQ-017 In pulse mode clk_out SHALL equal tick.
REQ-018 mode SHALL be sampled only at a wrap; when switching square->pulse, clk_out SHALL follow tick from that wrap; when switching pulse->square, clk_out SHALL start at 1 at that wrap (toggle from 0).
REQ-019 div_load with en high SHALL capture div_val into a shadow register and set load_pending; the shadow SHALL be applied to div_active at the next wrap, clearing load_pending.
REQ-020 div_load on the same edge as a wrap SHALL apply div_val directly at that wrap, with load_pending remaining low.
REQ-021 A second div_load before application SHALL overwrite the shadow (last write wins).
REQ-022 div_load with en low SHALL apply div_val to div_active on that edge, clear the counter to 0, and leave load_pending low.
REQ-023 With en low, counter and clk_out SHALL hold, and tick SHALL be 0; on re-enable, counting SHALL resume from the held value.
REQ-024 Counter arithmetic SHALL be CNT_W bits; the comparison against H-1 SHALL be an equality against the effective divisor, with no overflow path.
REQ-025 If div_active is reduced below the current count via the en-low load, the counter clear SHALL guarantee that count < H always holds.

Reset
REQ-026 While rst is high, outputs SHALL be: counter 0, clk_out 0, tick 0, load_pending 0, div_active = DEFAULT_DIV, sampled mode 0, shadow = DEFAULT_DIV.
REQ-027 Reset asserted mid-period SHALL abort the period immediately; the first wrap after release SHALL occur DEFAULT_DIV enabled cycles later.

Structure
REQ-028 A shared package clk_div_pkg SHALL hold: CNT_W default, DIV_1KHZ = 25000, DIV_1HZ = 25_000_000, and the mode encodings MODE_SQUARE = 0 and MODE_PULSE = 1.
REQ-029 The block SHALL be a single module with no sub-modules; counter, shadow register and output logic are too small to split.

Verification
REQ-030 Reset release, en = 1, defaults, 50 MHz -> first tick at cycle 25000; clk_out period 50000 cycles, 50% duty.
REQ-031 div_load with div_val = 4 at count 10 (H = 25000) -> load_pending high until the wrap at count 24999; then tick every 4 cycles and square period 8 cycles.
REQ-032 div_val = 0, then div_val = 1 -> both: tick constantly high, clk_out toggles every cycle, div_active shows 0 then 1.
REQ-033 mode = 1, H = 5 -> clk_out = tick, high 1 of every 5 cycles; switching to mode 0 mid-period changes nothing until the next wrap.
REQ-034 en low for 7 cycles at count 2 -> count, clk_out hold and tick stays 0; resume -> next wrap delayed by exactly 7 cycles. Same test with div_load = 3 while en low -> counter 0 and div_active = 3 immediately.
REQ-035 rst pulsed asynchronously (not clock-aligned) at count 12000 -> all outputs at reset values without waiting for an edge; div_active = 25000; next tick 25000 cycles after release.
